// File: rtl/aes_pkg.sv
// Shared AES field constants: composite-field GF((2^4)^2) basis maps, affine matrices and GF(2^4) helpers.
// Matrices are stored column-wise: element i is the image of input bit i.
package aes_pkg;

   typedef logic [7:0][7:0] mat8_t;

   localparam logic [7:0] AFFINE_C    = 8'h63;
   localparam logic [3:0] GF16_LAMBDA = 4'hC;

   // GF(2^4) product modulo x^4 + x + 1
   function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] s;
      p = '0;
      s = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p ^= s;
         s = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
      end
      return p;
   endfunction

   function automatic logic [3:0] gf16_sq(input logic [3:0] a);
      return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
   endfunction

   function automatic logic [7:0] mat_apply(input mat8_t m, input logic [7:0] v);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r ^= m[i];
      end
      return r;
   endfunction

   // Composite product: elements are hi*Y + lo with Y^2 = Y + lambda
   function automatic logic [7:0] gf256c_mul(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] hh;
      logic [3:0] hi;
      logic [3:0] lo;
      hh = gf16_mul(a[7:4], b[7:4]);
      hi = hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]);
      lo = gf16_mul(hh, GF16_LAMBDA) ^ gf16_mul(a[3:0], b[3:0]);
      return {hi, lo};
   endfunction

   // Finds a composite-field root of x^8+x^4+x^3+x+1; its powers form the map columns
   function automatic mat8_t build_iso_map();
      mat8_t      m;
      mat8_t      cols;
      logic [7:0] p;
      logic [7:0] acc;
      logic       found;
      m     = '0;
      cols  = '0;
      found = 1'b0;
      for (int b = 2; b < 256; b++) begin
         if (!found) begin
            p   = 8'h01;
            acc = 8'h00;
            for (int k = 0; k <= 8; k++) begin
               if (k < 8) cols[k] = p;
               if (k == 0 || k == 1 || k == 3 || k == 4 || k == 8) acc ^= p;
               p = gf256c_mul(p, 8'(b));
            end
            if (acc == 8'h00) begin
               m     = cols;
               found = 1'b1;
            end
         end
      end
      return m;
   endfunction

   function automatic mat8_t invert_map(input mat8_t m);
      mat8_t r;
      r = '0;
      for (int a = 0; a < 256; a++) begin
         for (int j = 0; j < 8; j++) begin
            if (mat_apply(m, 8'(a)) == (8'h01 << j)) r[j] = 8'(a);
         end
      end
      return r;
   endfunction

   function automatic mat8_t rot_matrix(input logic [7:0] rots);
      mat8_t m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < 8; r++) begin
            if (rots[r]) m[i][3'(i + r)] = 1'b1;
         end
      end
      return m;
   endfunction

   localparam mat8_t ISO_MAP     = build_iso_map();
   localparam mat8_t ISO_MAP_INV = invert_map(ISO_MAP);
   localparam mat8_t AFFINE_FWD  = rot_matrix(8'b0001_1111);
   localparam mat8_t AFFINE_INV  = rot_matrix(8'b0100_1010);

endpackage

// File: rtl/aes_Multiplier.sv
// Combinational GF(2^4) multiplier over x^4 + x + 1.
module aes_Multiplier
   import aes_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [3:0] p_o
);

   assign p_o = gf16_mul(a_i, b_i);

endmodule

// File: rtl/aes_gf16_inv.sv
// Combinational GF(2^4) multiplicative inverse over x^4 + x + 1; zero maps to zero.
module aes_gf16_inv (
   input  logic [3:0] d_i,
   output logic [3:0] d_inv_o
);

   always_comb begin
      d_inv_o = 4'h0;
      case (d_i)
         4'h1:    d_inv_o = 4'h1;
         4'h2:    d_inv_o = 4'h9;
         4'h3:    d_inv_o = 4'hE;
         4'h4:    d_inv_o = 4'hD;
         4'h5:    d_inv_o = 4'hB;
         4'h6:    d_inv_o = 4'h7;
         4'h7:    d_inv_o = 4'h6;
         4'h8:    d_inv_o = 4'hF;
         4'h9:    d_inv_o = 4'h2;
         4'hA:    d_inv_o = 4'hC;
         4'hB:    d_inv_o = 4'h5;
         4'hC:    d_inv_o = 4'hA;
         4'hD:    d_inv_o = 4'h4;
         4'hE:    d_inv_o = 4'h3;
         4'hF:    d_inv_o = 4'h8;
         default: d_inv_o = 4'h0;
      endcase
   end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Three-stage pipelined AES SubBytes / InvSubBytes using composite-field inversion.
// The whole pipe advances on one enable, so bubbles stay in place and a stall freezes every stage.
module aes_sbox_pipe
   import aes_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_inv_i,
   input  logic [7:0]       in_data_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [7:0]       out_data_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             busy_o
);

   logic             adv;
   logic             v1_q, v2_q, v3_q;
   logic [3:0]       hi1_q, lo1_q, d1_q, hi2_q, lo2_q, dInv2_q;
   logic             inv1_q, inv2_q;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
   logic [7:0]       data3_q;

   logic [7:0]       preIso;
   logic [7:0]       isoVal;
   logic [3:0]       hi1_d, lo1_d, d1_d, prod0;
   logic [3:0]       dInv2_d;
   logic [3:0]       hiOut, loOut;
   logic [7:0]       stdInv;
   logic [7:0]       data3_d;

   assign adv        = !v3_q || out_ready_i;
   assign in_ready_o = adv;

   // Stage 1: undo the affine step for InvSubBytes, move to the composite basis, form the norm d
   assign preIso = in_inv_i ? mat_apply(AFFINE_INV, in_data_i ^ AFFINE_C) : in_data_i;
   assign isoVal = mat_apply(ISO_MAP, preIso);
   assign hi1_d  = isoVal[7:4];
   assign lo1_d  = isoVal[3:0];

   aes_Multiplier u_mul0 (.a_i(lo1_d), .b_i(hi1_d ^ lo1_d), .p_o(prod0));

   assign d1_d = gf16_mul(GF16_LAMBDA, gf16_sq(hi1_d)) ^ prod0;

   aes_gf16_inv u_inv (.d_i(d1_q), .d_inv_o(dInv2_d));

   // Stage 3: rebuild the inverse, return to the AES basis, apply the forward affine for SubBytes
   aes_Multiplier u_mul1 (.a_i(hi2_q),         .b_i(dInv2_q), .p_o(hiOut));
   aes_Multiplier u_mul2 (.a_i(hi2_q ^ lo2_q), .b_i(dInv2_q), .p_o(loOut));

   assign stdInv  = mat_apply(ISO_MAP_INV, {hiOut, loOut});
   assign data3_d = inv2_q ? stdInv : (mat_apply(AFFINE_FWD, stdInv) ^ AFFINE_C);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         hi1_q   <= '0;
         lo1_q   <= '0;
         d1_q    <= '0;
         inv1_q  <= 1'b0;
         tag1_q  <= '0;
         hi2_q   <= '0;
         lo2_q   <= '0;
         dInv2_q <= '0;
         inv2_q  <= 1'b0;
         tag2_q  <= '0;
         data3_q <= '0;
         tag3_q  <= '0;
      end else if (adv) begin
         v1_q    <= in_valid_i & in_ready_o;
         v2_q    <= v1_q;
         v3_q    <= v2_q;
         hi1_q   <= hi1_d;
         lo1_q   <= lo1_d;
         d1_q    <= d1_d;
         inv1_q  <= in_inv_i;
         tag1_q  <= in_tag_i;
         hi2_q   <= hi1_q;
         lo2_q   <= lo1_q;
         dInv2_q <= dInv2_d;
         inv2_q  <= inv1_q;
         tag2_q  <= tag1_q;
         data3_q <= data3_d;
         tag3_q  <= tag2_q;
      end
   end

   assign out_valid_o = v3_q;
   assign out_data_o  = data3_q;
   assign out_tag_o   = tag3_q;
   assign busy_o      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: FIPS-197 table sweeps, backpressure, mixed ops, bubbles and async reset.
module tb_aes_sbox_pipe;

   localparam int TAG_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             in_valid_i = 1'b0;
   logic             in_ready_o;
   logic             in_inv_i = 1'b0;
   logic [7:0]       in_data_i = '0;
   logic [TAG_W-1:0] in_tag_i = '0;
   logic             out_valid_o;
   logic             out_ready_i = 1'b1;
   logic [7:0]       out_data_o;
   logic [TAG_W-1:0] out_tag_o;
   logic             busy_o;

   aes_sbox_pipe #(.TAG_W(TAG_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_inv_i    (in_inv_i),
      .in_data_i   (in_data_i),
      .in_tag_i    (in_tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_tag_o   (out_tag_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic [7:0] invSbox [256];

   typedef struct {
      logic [7:0]       data;
      logic [TAG_W-1:0] tag;
      int               acceptCycle;
   } expItem_t;

   expItem_t expQ[$];
   expItem_t monItem;
   int       compareCount = 0;
   int       mismatchCount = 0;
   int       cycleCount = 0;
   int       lastOutCycle = -1;
   int       prevOutCycle = -1;
   bit       checkLatency = 1'b0;

   // Every comparison in the bench funnels through here so the counters stay honest
   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d", name, observed, expected, cycleCount);
      end
   endtask

   // Offers one byte, waits (bounded) until it is taken, and queues its hand-known result
   task automatic applyStimulus(input logic inv, input logic [7:0] d, input logic [TAG_W-1:0] t,
                                input logic [7:0] expData);
      int waited;
      waited     = 0;
      in_valid_i = 1'b1;
      in_inv_i   = inv;
      in_data_i  = d;
      in_tag_i   = t;
      @(negedge clk_i);
      while (!in_ready_o && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      if (waited >= 50) begin
         checkOutput("acceptTimeout", 32'(in_ready_o), 32'd1);
      end else begin
         expQ.push_back('{data: expData, tag: t, acceptCycle: cycleCount});
         @(posedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
   endtask

   // Lets the pipe empty out, bounded, then realigns to just after a rising edge
   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || busy_o) && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("drainBusy", 32'(busy_o), 32'd0);
      checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   // Free-running cycle counter used for latency and spacing measurements
   always @(posedge clk_i) cycleCount <= cycleCount + 1;

   // Output monitor: any transfer at the coming edge must match the oldest queued expectation
   always @(negedge clk_i) begin
      if (out_valid_o && out_ready_i) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedOutput", 32'(out_valid_o), 32'd0);
         end else begin
            monItem = expQ.pop_front();
            checkOutput("outData", 32'(out_data_o), 32'(monItem.data));
            checkOutput("outTag", 32'(out_tag_o), 32'(monItem.tag));
            if (checkLatency) checkOutput("latency", 32'(cycleCount - monItem.acceptCycle), 32'd3);
         end
         prevOutCycle = lastOutCycle;
         lastOutCycle = cycleCount;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] x;
      logic [7:0] d;
      logic       inv;

      for (int i = 0; i < 256; i++) invSbox[SBOX[i]] = 8'(i);

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rstOutValid", 32'(out_valid_o), 32'd0);
      checkOutput("rstBusy", 32'(busy_o), 32'd0);
      checkOutput("rstOutData", 32'(out_data_o), 32'd0);
      checkOutput("rstOutTag", 32'(out_tag_o), 32'd0);
      rst_i = 1'b0;
      checkOutput("rstInReady", 32'(in_ready_o), 32'd1);

      // Forward sweep, back-to-back, with latency checked on every byte
      $display("[TB] forward sweep");
      checkLatency = 1'b1;
      for (int i = 0; i < 256; i++) applyStimulus(1'b0, 8'(i), 4'(i), SBOX[i]);
      waitDrain();
      checkLatency = 1'b0;
      applyStimulus(1'b0, 8'h00, 4'h1, 8'h63);
      applyStimulus(1'b0, 8'h53, 4'h2, 8'hED);
      applyStimulus(1'b0, 8'hFF, 4'h3, 8'h16);
      waitDrain();

      // Inverse sweep plus hand-known corner bytes
      $display("[TB] inverse sweep");
      checkLatency = 1'b1;
      for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), 4'(i), invSbox[i]);
      waitDrain();
      checkLatency = 1'b0;
      applyStimulus(1'b1, 8'h63, 4'h4, 8'h00);
      applyStimulus(1'b1, 8'hED, 4'h5, 8'h53);
      applyStimulus(1'b1, 8'h16, 4'h6, 8'hFF);
      for (int k = 0; k < 16; k++) begin
         x = 8'(k * 16 + 7);
         applyStimulus(1'b0, invSbox[x], 4'(k), x);
      end
      waitDrain();

      // Backpressure: freeze after the first result appears
      $display("[TB] backpressure");
      fork
         begin
            applyStimulus(1'b0, 8'h01, 4'h1, 8'h7C);
            applyStimulus(1'b0, 8'h02, 4'h2, 8'h77);
            applyStimulus(1'b0, 8'h03, 4'h3, 8'h7B);
            applyStimulus(1'b0, 8'h04, 4'h4, 8'hF2);
         end
         begin
            int w;
            w = 0;
            while (!out_valid_o && w < 20) begin
               @(posedge clk_i);
               #1;
               w++;
            end
            checkOutput("bpFirstValid", 32'(out_valid_o), 32'd1);
            out_ready_i = 1'b0;
            repeat (5) begin
               @(negedge clk_i);
               checkOutput("bpHoldValid", 32'(out_valid_o), 32'd1);
               checkOutput("bpHoldData", 32'(out_data_o), 32'h7C);
               checkOutput("bpHoldTag", 32'(out_tag_o), 32'h1);
               checkOutput("bpInReady", 32'(in_ready_o), 32'd0);
            end
            @(posedge clk_i);
            #1;
            out_ready_i = 1'b1;
         end
      join
      waitDrain();

      // Alternating operations, each carrying its own tag
      $display("[TB] mixed ops");
      for (int t = 0; t < 16; t++) begin
         inv = (t % 2) == 1;
         d   = 8'(t * 37 + 11);
         applyStimulus(inv, d, 4'(t), inv ? invSbox[d] : SBOX[d]);
      end
      waitDrain();

      // Bubbles keep their spacing and busy clears three cycles after the last accept
      $display("[TB] bubbles");
      applyStimulus(1'b0, 8'h10, 4'hA, 8'hCA);
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      applyStimulus(1'b0, 8'h20, 4'hB, 8'hB7);
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      checkOutput("bubbleBusyHeld", 32'(busy_o), 32'd1);
      @(posedge clk_i);
      #1;
      checkOutput("bubbleBusyDrop", 32'(busy_o), 32'd0);
      checkOutput("bubbleSpacing", 32'(lastOutCycle - prevOutCycle), 32'd3);
      waitDrain();

      // Asynchronous reset while the pipe is full and stalled
      $display("[TB] async reset");
      out_ready_i = 1'b0;
      applyStimulus(1'b0, 8'h01, 4'h7, 8'h7C);
      applyStimulus(1'b0, 8'h02, 4'h8, 8'h77);
      applyStimulus(1'b0, 8'h03, 4'h9, 8'h7B);
      @(posedge clk_i);
      #1;
      checkOutput("arStalledValid", 32'(out_valid_o), 32'd1);
      checkOutput("arStalledReady", 32'(in_ready_o), 32'd0);
      #3;
      rst_i = 1'b1;
      #1;
      expQ.delete();
      checkOutput("arOutValid", 32'(out_valid_o), 32'd0);
      checkOutput("arBusy", 32'(busy_o), 32'd0);
      checkOutput("arOutData", 32'(out_data_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      out_ready_i = 1'b1;
      checkOutput("arInReady", 32'(in_ready_o), 32'd1);
      repeat (6) begin
         @(negedge clk_i);
         checkOutput("arNoStale", 32'(out_valid_o), 32'd0);
      end
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
